// File: rtl/vga_pkg.sv
// Timing constants for the 800x600@60 Hz (40 MHz pixel clock) video pipeline,
// plus the overlay image sizes shared with the later stages.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam logic [CNT_W-1:0] H_VISIBLE = 11'd800;
    localparam logic [CNT_W-1:0] H_FRONT   = 11'd40;
    localparam logic [CNT_W-1:0] H_SYNC    = 11'd128;
    localparam logic [CNT_W-1:0] H_BACK    = 11'd88;
    localparam logic [CNT_W-1:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [CNT_W-1:0] V_VISIBLE = 11'd600;
    localparam logic [CNT_W-1:0] V_FRONT   = 11'd1;
    localparam logic [CNT_W-1:0] V_SYNC    = 11'd4;
    localparam logic [CNT_W-1:0] V_BACK    = 11'd23;
    localparam logic [CNT_W-1:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] HSYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [CNT_W-1:0] HSYNC_END   = HSYNC_START + H_SYNC - 11'd1;
    localparam logic [CNT_W-1:0] VSYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [CNT_W-1:0] VSYNC_END   = VSYNC_START + V_SYNC - 11'd1;

    // Overlay image sizes consumed by the image-overlay stages.
    localparam logic [CNT_W-1:0] A_SIDE = 11'd64;
    localparam logic [CNT_W-1:0] B_SIDE = 11'd128;

endpackage

// File: rtl/timing_counter.sv
// Wrap counter 0..MAX with enable; also exposes its next-state value so the
// parent can register flags aligned with the count.
module timing_counter
    import vga_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX = 11'd1055
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] nxt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = inc_en && (cnt_q == MAX);
        cnt_d = cnt_q;
        if (wrap)
            cnt_d = '0;
        else if (inc_en)
            cnt_d = cnt_q + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running 800x600@60 VGA timing generator; the vga_if bundle is carried as flat ports.
// Optional frame counter output enabled by `define VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic [11:0] rgb,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_wrap, v_wrap;

    timing_counter #(.MAX(H_TOTAL - 11'd1)) u_hcnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (1'b1),
        .cnt    (h_cnt),
        .nxt    (h_nxt),
        .wrap   (h_wrap)
    );

    timing_counter #(.MAX(V_TOTAL - 11'd1)) u_vcnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (h_wrap),
        .cnt    (v_cnt),
        .nxt    (v_nxt),
        .wrap   (v_wrap)
    );

    // Flags decode the next-state counts so they land on the same edge as the counts.
    logic hsync_q, hsync_d, vsync_q, vsync_d;
    logic hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic fstart_q, fstart_d;

    always_comb begin
        hblnk_d  = (h_nxt >= H_VISIBLE);
        hsync_d  = (h_nxt >= HSYNC_START) && (h_nxt <= HSYNC_END);
        vblnk_d  = (v_nxt >= V_VISIBLE);
        vsync_d  = (v_nxt >= VSYNC_START) && (v_nxt <= VSYNC_END);
        fstart_d = v_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            fstart_q <= fstart_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            frame_cnt_q <= '0;
        else if (fstart_d)
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hcount      = h_cnt;
    assign vcount      = v_cnt;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign rgb         = 12'h000;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: a position-in-frame reference model checked every cycle.
// Long frame distances are reached by depositing counter state near the points of interest.
module tb_vga_timing_gen;

    localparam int HT    = 1056;
    localparam int VT    = 628;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk, frame_start;
    logic [11:0] rgb;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_gen dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblnk       (hblnk),
        .vblnk       (vblnk),
        .rgb         (rgb),
        .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference state: linear pixel position within the frame, plus frame events.
    int p  = 0;
    bit fs = 1'b0;
    int fc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all();
        int h, v;
        h = p % HT;
        v = p / HT;
        chk("hcount", 32'(hcount), 32'(h));
        chk("vcount", 32'(vcount), 32'(v));
        chk("hblnk", 32'(hblnk), 32'(h >= 800));
        chk("hsync", 32'(hsync), 32'(h >= 840 && h <= 967));
        chk("vblnk", 32'(vblnk), 32'(v >= 600));
        chk("vsync", 32'(vsync), 32'(v >= 601 && v <= 604));
        chk("rgb", 32'(rgb), 32'(0));
        chk("frame_start", 32'(frame_start), 32'(fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(fc));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            p  = 0;
            fs = 1'b0;
            fc = 0;
        end else begin
            p  = (p + 1) % FRAME;
            fs = (p == 0);
            if (fs) fc = (fc + 1) & 32'hFFFF;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Jump the frame position; registered flags realign on the next edge.
    task automatic deposit(input int h, input int v);
        dut.u_hcnt.cnt_q = 11'(h);
        dut.u_vcnt.cnt_q = 11'(v);
        p  = v * HT + h;
        fs = 1'b0;
    endtask

    initial begin
        int rise_h, fall_h, hs_len, vs_len, vb_rise_h, vb_rise_v, fs_cnt;
        logic prev;

        // Reset held from time zero, then again mid-count for 5 cycles.
        @(negedge clk);
        run(3);
        rst = 1'b1;
        run(300);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_hcount", 32'(hcount), 32'(0));
            chk("rst_flags", 32'({hsync, vsync, hblnk, vblnk, frame_start}), 32'(0));
        end
        rst = 1'b1;
        step();
        chk("release_hcount", 32'(hcount), 32'(1));
        chk("release_vcount", 32'(vcount), 32'(0));

        // One line: blanking and hsync boundaries.
        rise_h = -1; fall_h = -1; hs_len = 0; prev = hsync;
        for (int i = 0; i < HT - 1; i++) begin
            step();
            if (p % HT == 799) chk("hblnk_at_799", 32'(hblnk), 32'(0));
            if (p % HT == 800) chk("hblnk_at_800", 32'(hblnk), 32'(1));
            if (hsync && !prev) rise_h = p % HT;
            if (!hsync && prev) fall_h = p % HT;
            if (hsync) hs_len++;
            prev = hsync;
        end
        chk("line_end_hcount", 32'(hcount), 32'(0));
        chk("line_end_vcount", 32'(vcount), 32'(1));
        chk("hsync_rise_h", 32'(rise_h), 32'(840));
        chk("hsync_fall_h", 32'(fall_h), 32'(968));
        chk("hsync_width", 32'(hs_len), 32'(128));

        // Frame tail: vblnk/vsync and the wrap to (0,0).
        deposit(0, 598);
        vs_len = 0; fs_cnt = 0; vb_rise_h = -1; vb_rise_v = -1;
        prev = 1'b0;
        for (int i = 0; i < (VT - 598) * HT + 1500; i++) begin
            step();
            if (vblnk && !prev) begin
                vb_rise_h = 32'(hcount);
                vb_rise_v = 32'(vcount);
            end
            prev = vblnk;
            if (vsync) vs_len++;
            if (frame_start) begin
                fs_cnt++;
                chk("wrap_pos", 32'({vcount, hcount}), 32'(0));
            end
        end
        chk("vblnk_rise_h", 32'(vb_rise_h), 32'(0));
        chk("vblnk_rise_v", 32'(vb_rise_v), 32'(600));
        chk("vsync_cycles", 32'(vs_len), 32'(4 * HT));
        chk("frame_start_pulses", 32'(fs_cnt), 32'(1));

        // One-cycle reset at (500,300).
        deposit(499, 300);
        step();
        chk("pre_rst_pos_h", 32'(hcount), 32'(500));
        rst = 1'b0;
        step();
        chk("mid_rst_pos", 32'({vcount, hcount}), 32'(0));
        chk("mid_rst_flags", 32'({hsync, vsync, hblnk, vblnk, frame_start}), 32'(0));
        rst = 1'b1;
        run(200);

        // Randomized jumps and reset pulses, model-checked on every cycle.
        for (int k = 0; k < 10; k++) begin
            deposit(int'($urandom_range(HT - 1, 0)), int'($urandom_range(VT - 1, 0)));
            run(int'($urandom_range(1800, 200)));
            if ($urandom_range(2, 0) == 0) begin
                rst = 1'b0;
                run(int'($urandom_range(3, 1)));
                rst = 1'b1;
                run(50);
            end
        end
        // Near-wrap jumps so random runs cross the frame boundary too.
        for (int k = 0; k < 4; k++) begin
            deposit(int'($urandom_range(HT - 1, 0)), VT - 1);
            run(int'($urandom_range(2200, 1100)));
        end

`ifdef VGA_TIMING_FRAME_CNT_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            deposit(1040, VT - 1);
            run(30);
        end
        chk("frame_cnt_after_3", 32'(frame_cnt), 32'(3));
        dut.frame_cnt_q = 16'hFFFF;
        fc = 32'hFFFF;
        deposit(1050, VT - 1);
        run(30);
        chk("frame_cnt_rollover", 32'(frame_cnt), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
